// File: rtl/jk_latch.sv
// jk_latch: WIDTH independent edge-triggered JK bit-cells with a synchronous,
// active-high reset to RESET_VAL. Q_not is always the bitwise complement of Q.
// Optional clock enable: define JK_LATCH_CE_EN to add a 'ce' port after 'rst'.
// Reset ignores ce; with ce low and rst low every bit holds.
module jk_latch #(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             clk,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_not,
    input  logic             rst
`ifdef JK_LATCH_CE_EN
    ,
    input  logic             ce
`endif
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic             en;

`ifdef JK_LATCH_CE_EN
    assign en = ce;
`else
    assign en = 1'b1;
`endif

    // Per-bit JK characteristic equation: Q+ = J&~Q | ~K&Q
    always_comb begin
        q_next = (J & ~q_r) | (~K & q_r);
    end

    // State register: reset has priority, then the enabled JK update
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= RESET_VAL;
        end else if (en) begin
            q_r <= q_next;
        end
    end

    assign Q     = q_r;
    assign Q_not = ~q_r;

endmodule

// File: tb/tb_jk_latch.sv
// tb_jk_latch: directed self-checking bench for jk_latch (1-bit and 4-bit cells).
module tb_jk_latch;

    logic       clk = 1'b0;
    logic       j1, k1, rst1;
    logic       q1, qn1;
    logic [3:0] j4, k4;
    logic       rst4;
    logic [3:0] q4, qn4;
`ifdef JK_LATCH_CE_EN
    logic       ce;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jk_latch #(.WIDTH(1)) u1 (
        .J(j1), .K(k1), .clk(clk), .Q(q1), .Q_not(qn1), .rst(rst1)
`ifdef JK_LATCH_CE_EN
        , .ce(ce)
`endif
    );

    jk_latch #(.WIDTH(4), .RESET_VAL(4'b0011)) u4 (
        .J(j4), .K(k4), .clk(clk), .Q(q4), .Q_not(qn4), .rst(rst4)
`ifdef JK_LATCH_CE_EN
        , .ce(ce)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic exp);
        check(tag, {63'd0, q1}, {63'd0, exp});
        check({tag, "_n"}, {63'd0, qn1}, {63'd0, ~exp});
    endtask

    task automatic chk4(input string tag, input logic [3:0] exp);
        check(tag, {60'd0, q4}, {60'd0, exp});
        check({tag, "_n"}, {60'd0, qn4}, {60'd0, ~exp});
    endtask

    initial begin
`ifdef JK_LATCH_CE_EN
        ce = 1'b1;
`endif
        // Reset with J=K=1 must still give RESET_VAL
        rst1 = 1'b1; j1 = 1'b1; k1 = 1'b1;
        rst4 = 1'b1; j4 = 4'b1111; k4 = 4'b1111;
        @(negedge clk);
        tick();
        chk1("reset1", 1'b0);
        chk4("reset4", 4'b0011);

        // Hold / reset / set / hold
        rst1 = 1'b0; j1 = 1'b0; k1 = 1'b0; tick(); chk1("hold0", 1'b0);
        j1 = 1'b0; k1 = 1'b1; tick(); chk1("clr0", 1'b0);
        j1 = 1'b1; k1 = 1'b0; tick(); chk1("set", 1'b1);
        j1 = 1'b0; k1 = 1'b0; tick(); chk1("hold1", 1'b1);

        // Toggle for 4 edges from Q=1
        j1 = 1'b1; k1 = 1'b1;
        tick(); chk1("tog1", 1'b0);
        tick(); chk1("tog2", 1'b1);
        tick(); chk1("tog3", 1'b0);
        tick(); chk1("tog4", 1'b1);

        // Reset on the 3rd toggle edge, resume on the next
        tick(); chk1("rtog1", 1'b0);
        tick(); chk1("rtog2", 1'b1);
        rst1 = 1'b1; tick(); chk1("rtog3_rst", 1'b0);
        rst1 = 1'b0; tick(); chk1("rtog4_resume", 1'b1);

        // Mid-cycle glitch on J/K must not reach Q
        j1 = 1'b0; k1 = 1'b1;
        #3;
        chk1("glitch_mid", 1'b1);
        j1 = 1'b0; k1 = 1'b0;
        tick(); chk1("glitch_edge", 1'b1);

        // 4-bit independence: set, clear, toggle, hold in one edge
        rst4 = 1'b0; j4 = 4'b1010; k4 = 4'b0110;
        tick(); chk4("w4_mix", 4'b1001);
        j4 = 4'b0101; k4 = 4'b0101;
        tick(); chk4("w4_tog", 4'b1100);
        j4 = 4'b0000; k4 = 4'b0000;
        tick(); chk4("w4_hold", 4'b1100);

`ifdef JK_LATCH_CE_EN
        // Clock enable: hold when low, update when high, reset ignores it
        rst1 = 1'b1; tick(); chk1("ce_rst", 1'b0);
        rst1 = 1'b0; ce = 1'b0; j1 = 1'b1; k1 = 1'b0;
        tick(); chk1("ce_off", 1'b0);
        ce = 1'b1; tick(); chk1("ce_on", 1'b1);
        ce = 1'b0; rst1 = 1'b1; tick(); chk1("ce_off_rst", 1'b0);
        rst1 = 1'b0; ce = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_latch.md
JK_LATCH -- requirements
Module: jk_latch

Interface
REQ-001 Parameter WIDTH, default 1, number of independent JK bit-cells (1..64).
REQ-002 Parameter RESET_VAL, default {WIDTH{1'b0}}, value loaded into Q on reset.
REQ-003 Port J, input, WIDTH; per-bit set request.
REQ-004 Port K, input, WIDTH; per-bit reset request.
REQ-005 Port clk, input, 1; the only clock; all state updates on its rising edge.
REQ-006 Port Q, output, WIDTH; registered state.
REQ-007 Port Q_not, output, WIDTH; bitwise complement of Q.
REQ-008 Port rst, input, 1; reset is synchronous and active-high.
REQ-009 Positional port order SHALL be J, K, clk, Q, Q_not, rst (then ce when compiled in).

Function
REQ-010 Each bit i SHALL update only on the rising edge of clk, using J[i], K[i] sampled at that edge.
REQ-011 J=0,K=0: Q[i] SHALL hold.
REQ-012 J=0,K=1: Q[i] SHALL become 0.
REQ-013 J=1,K=0: Q[i] SHALL become 1.
REQ-014 J=1,K=1: Q[i] SHALL invert on every rising edge while both stay high.
REQ-015 Latency SHALL be one clock: the new Q is visible after the edge, and the value read at an edge is the pre-update state.
REQ-016 Q_not SHALL equal ~Q combinationally at all times, including during and after reset, never driven X once rst has been sampled.
REQ-017 Bits SHALL be fully independent; no bit's inputs affect another bit.
REQ-018 J/K changes between rising edges SHALL NOT affect Q (no level-sensitive transparency).
REQ-019 X/Z on J or K at an edge SHALL NOT be resolved by the block; behaviour is undefined for that bit only.

Reset
REQ-020 When rst=1 at a rising edge, Q SHALL become RESET_VAL and Q_not ~RESET_VAL, regardless of J, K (and ce).
REQ-021 Reset SHALL take priority over all JK actions, including a toggle in progress.
REQ-022 Before the first reset edge, Q is unspecified; the bench SHALL assert rst for at least one edge.
REQ-023 On the first edge with rst=0 after reset, normal JK operation SHALL resume on that edge.

Configuration
REQ-024 Macro JK_LATCH_CE_EN: when defined, a port ce (input, 1, active-high clock enable) SHALL be added after rst; with ce=0 and rst=0, Q SHALL hold regardless of J, K; reset SHALL ignore ce.
REQ-025 Without JK_LATCH_CE_EN, no ce port SHALL exist and every non-reset edge SHALL be enabled.

Verification
REQ-026 Reset: rst=1, J=1, K=1, one edge -> Q=0, Q_not=1 (RESET_VAL=0).
REQ-027 Hold/reset/set: from Q=0, J=0 K=0 edge -> Q=0; J=0 K=1 -> Q=0; J=1 K=0 -> Q=1, Q_not=0; J=0 K=0 -> Q stays 1.
REQ-028 Toggle: from Q=1, J=1 K=1 held for 4 edges -> Q sequence 0,1,0,1; Q_not always the complement.
REQ-029 Reset during toggle: J=K=1 toggling, rst=1 on the 3rd edge -> Q=0 at that edge; rst=0 on the next edge -> Q=1.
REQ-030 WIDTH=4: J=4'b1010, K=4'b0110 from Q=4'b0011 -> Q=4'b1001 after one edge.
REQ-031 With JK_LATCH_CE_EN: ce=0, J=1 K=0 from Q=0 -> Q stays 0; ce=1 -> Q=1; ce=0 with rst=1 -> Q=0.
